// File: rtl/comparator_688.sv
// comparator_688: 74x688-style identity comparator with registered status and edge pulses.
// Optional statistics counters are enabled by defining COMPARATOR_688_STATS_EN.
module comparator_688 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ng,
`ifdef COMPARATOR_688_STATS_EN
  input  logic             clr_stats,
  output logic [15:0]      match_cnt,
  output logic [15:0]      event_cnt,
`endif
  output logic             neq,
  output logic [WIDTH-1:0] diff,
  output logic             neq_q,
  output logic [WIDTH-1:0] diff_q,
  output logic             eq_rise,
  output logic             eq_fall
);
  logic             w_neq;
  logic             r_neq_q;
  logic [WIDTH-1:0] r_diff_q;
  logic             r_eq_rise;
  logic             r_eq_fall;
  logic             r_first;
  // An if-statement (not a ternary) so an unknown condition falls to "unequal".
  always_comb begin
    w_neq = 1'b1;
    if (!ng && a == b) w_neq = 1'b0;
  end
  always_ff @(posedge clk) begin
    r_first   <= reset;
    r_neq_q   <= reset ? 1'b1 : w_neq;
    r_diff_q  <= reset ? '0 : a ^ b;
    r_eq_rise <= !reset && !r_first && r_neq_q && !w_neq;
    r_eq_fall <= !reset && !r_first && !r_neq_q && w_neq;
  end
`ifdef COMPARATOR_688_STATS_EN
  logic [15:0] r_match_cnt;
  logic [15:0] r_event_cnt;
  always_ff @(posedge clk) begin
    r_match_cnt <= (reset || clr_stats) ? 16'd0 :
                   (!r_neq_q && r_match_cnt != 16'hFFFF) ? r_match_cnt + 16'd1 : r_match_cnt;
    r_event_cnt <= (reset || clr_stats) ? 16'd0 :
                   (r_eq_rise && r_event_cnt != 16'hFFFF) ? r_event_cnt + 16'd1 : r_event_cnt;
  end
  assign match_cnt = r_match_cnt;
  assign event_cnt = r_event_cnt;
`endif
  assign neq     = w_neq;
  assign diff    = a ^ b;
  assign neq_q   = r_neq_q;
  assign diff_q  = r_diff_q;
  assign eq_rise = r_eq_rise;
  assign eq_fall = r_eq_fall;
endmodule

// File: tb/tb_comparator_688.sv
// tb_comparator_688: directed self-checking bench for comparator_688.
module tb_comparator_688;
  logic       clk, reset, ng;
  logic [7:0] a, b;
  logic       neq, neq_q, eq_rise, eq_fall;
  logic [7:0] diff, diff_q;
  int         n_cmp = 0;
  int         n_err = 0;
`ifdef COMPARATOR_688_STATS_EN
  logic        clr_stats;
  logic [15:0] match_cnt, event_cnt;
`endif

  comparator_688 #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .ng(ng),
`ifdef COMPARATOR_688_STATS_EN
    .clr_stats(clr_stats), .match_cnt(match_cnt), .event_cnt(event_cnt),
`endif
    .neq(neq), .diff(diff), .neq_q(neq_q), .diff_q(diff_q),
    .eq_rise(eq_rise), .eq_fall(eq_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; ng = 1'b0; a = 8'h5A; b = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_cmp++; if (neq !== 1'b0) begin n_err++; $display("FAIL rst_neq: got %b want 0", neq); end
      n_cmp++; if (neq_q !== 1'b1) begin n_err++; $display("FAIL rst_neq_q: got %b want 1", neq_q); end
      n_cmp++; if (diff_q !== 8'h00) begin n_err++; $display("FAIL rst_diff_q: got %h want 00", diff_q); end
      n_cmp++; if ({eq_rise, eq_fall} !== 2'b00) begin n_err++; $display("FAIL rst_pulse: got %b want 00", {eq_rise, eq_fall}); end
    end
    reset = 1'b0;
    tick;
    n_cmp++; if (neq_q !== 1'b0) begin n_err++; $display("FAIL rel_neq_q: got %b want 0", neq_q); end
    n_cmp++; if (eq_rise !== 1'b0) begin n_err++; $display("FAIL rel_no_rise: got %b want 0", eq_rise); end
    ng = 1'b1;
    tick;
    n_cmp++; if (neq_q !== 1'b1) begin n_err++; $display("FAIL ng1_neq_q: got %b want 1", neq_q); end
    n_cmp++; if ({eq_rise, eq_fall} !== 2'b01) begin n_err++; $display("FAIL ng1_fall: got %b want 01", {eq_rise, eq_fall}); end
    ng = 1'b0;
    tick;
    n_cmp++; if (neq_q !== 1'b0) begin n_err++; $display("FAIL ng0_neq_q: got %b want 0", neq_q); end
    n_cmp++; if ({eq_rise, eq_fall} !== 2'b10) begin n_err++; $display("FAIL ng0_rise: got %b want 10", {eq_rise, eq_fall}); end
    tick;
    n_cmp++; if ({eq_rise, eq_fall} !== 2'b00) begin n_err++; $display("FAIL steady: got %b want 00", {eq_rise, eq_fall}); end
    reset = 1'b1;
    tick;
    n_cmp++; if (neq_q !== 1'b1) begin n_err++; $display("FAIL rst_hold_neq_q: got %b want 1", neq_q); end
    n_cmp++; if (eq_fall !== 1'b0) begin n_err++; $display("FAIL rst_hold_fall: got %b want 0", eq_fall); end
    n_cmp++; if (neq !== 1'b0) begin n_err++; $display("FAIL rst_hold_neq: got %b want 0", neq); end
    reset = 1'b0;
    tick;
    n_cmp++; if ({neq_q, eq_rise} !== 2'b00) begin n_err++; $display("FAIL rel2: got %b want 00", {neq_q, eq_rise}); end
  endtask

  task automatic test_diff;
    a = 8'hF0; b = 8'h0F;
    #1;
    n_cmp++; if (diff !== 8'hFF) begin n_err++; $display("FAIL diff: got %h want ff", diff); end
    n_cmp++; if (neq !== 1'b1) begin n_err++; $display("FAIL diff_neq: got %b want 1", neq); end
    tick;
    n_cmp++; if (diff_q !== 8'hFF) begin n_err++; $display("FAIL diff_q: got %h want ff", diff_q); end
    n_cmp++; if ({neq_q, eq_fall} !== 2'b11) begin n_err++; $display("FAIL diff_neq_q: got %b want 11", {neq_q, eq_fall}); end
    ng = 1'b1; a = 8'h3C; b = 8'h3D;
    #1;
    n_cmp++; if (diff !== 8'h01) begin n_err++; $display("FAIL diff_ng: got %h want 01", diff); end
    tick;
    n_cmp++; if (diff_q !== 8'h01) begin n_err++; $display("FAIL diff_q_ng: got %h want 01", diff_q); end
  endtask

  task automatic test_glitch;
    ng = 1'b0; a = 8'h11; b = 8'h22;
    tick; tick;
    n_cmp++; if ({eq_rise, eq_fall} !== 2'b00) begin n_err++; $display("FAIL gl_idle: got %b want 00", {eq_rise, eq_fall}); end
    b = 8'h11;
    tick;
    n_cmp++; if ({neq_q, eq_rise, eq_fall} !== 3'b010) begin n_err++; $display("FAIL gl_rise: got %b want 010", {neq_q, eq_rise, eq_fall}); end
    b = 8'h22;
    tick;
    n_cmp++; if ({neq_q, eq_rise, eq_fall} !== 3'b101) begin n_err++; $display("FAIL gl_fall: got %b want 101", {neq_q, eq_rise, eq_fall}); end
    tick;
    n_cmp++; if ({eq_rise, eq_fall} !== 2'b00) begin n_err++; $display("FAIL gl_end: got %b want 00", {eq_rise, eq_fall}); end
  endtask

  task automatic test_xsafe;
    logic e;
    ng = 1'b0; a = 8'h00; b = 8'h0x;
    #1;
    e = $isunknown({a, b, ng}) ? 1'b1 : (ng | (a != b));
    n_cmp++; if (neq !== e) begin n_err++; $display("FAIL x_b: got %b want %b", neq, e); end
    b = 8'h00; ng = 1'bx;
    #1;
    e = $isunknown({a, b, ng}) ? 1'b1 : (ng | (a != b));
    n_cmp++; if (neq !== e) begin n_err++; $display("FAIL x_ng: got %b want %b", neq, e); end
    ng = 1'b0;
    #1;
    n_cmp++; if (neq !== 1'b0) begin n_err++; $display("FAIL x_clear: got %b want 0", neq); end
  endtask

  task automatic test_sweep;
    logic e;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 256; i++) begin
        for (int k = -1; k < 8; k++) begin
          ng = g[0];
          a = i[7:0];
          b = (k < 0) ? i[7:0] : i[7:0] ^ (8'd1 << k);
          #30;
          e = (g != 0) || (k >= 0);
          n_cmp++; if (neq !== e) begin n_err++; $display("FAIL sweep ng=%0d a=%h b=%h: got %b want %b", g, a, b, neq, e); end
          #10;
        end
      end
    end
  endtask

`ifdef COMPARATOR_688_STATS_EN
  task automatic test_stats;
    ng = 1'b0; a = 8'h01; b = 8'h02; clr_stats = 1'b0;
    tick; tick;
    clr_stats = 1'b1;
    tick;
    clr_stats = 1'b0;
    n_cmp++; if ({match_cnt, event_cnt} !== 32'd0) begin n_err++; $display("FAIL st_clr0: got %h/%h want 0/0", match_cnt, event_cnt); end
    for (int i = 0; i < 3; i++) begin
      b = 8'h01; tick; tick;
      b = 8'h02; tick; tick;
    end
    n_cmp++; if (match_cnt !== 16'd6) begin n_err++; $display("FAIL st_match: got %0d want 6", match_cnt); end
    n_cmp++; if (event_cnt !== 16'd3) begin n_err++; $display("FAIL st_event: got %0d want 3", event_cnt); end
    b = 8'h01; clr_stats = 1'b1;
    tick;
    clr_stats = 1'b0;
    n_cmp++; if ({match_cnt, event_cnt} !== 32'd0) begin n_err++; $display("FAIL st_clr: got %h/%h want 0/0", match_cnt, event_cnt); end
    tick;
    n_cmp++; if ({match_cnt, event_cnt} !== {16'd1, 16'd1}) begin n_err++; $display("FAIL st_after_clr: got %0d/%0d want 1/1", match_cnt, event_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1; ng = 1'b0; a = 8'h00; b = 8'h00;
`ifdef COMPARATOR_688_STATS_EN
    clr_stats = 1'b0;
`endif
    test_reset;
    test_diff;
    test_glitch;
    test_xsafe;
    test_sweep;
`ifdef COMPARATOR_688_STATS_EN
    test_stats;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
